djs130_tto: RTL and testbench
=============================

Name: djs130_tto

Overview:
Teletype output (TTO) device controller for the DJS130 I/O bus. It is the transmit counterpart of the TTI keyboard input device. The CPU loads a character with DOA and issues Start. The block serialises the character onto an asynchronous 8N1 line, then sets Done and raises an interrupt request. It sits on the device bus beside the TTI and drives the teletype/UART TX pin.

Parameters:
BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
DEV_CODE, 6'o11, device code reported on o_dev_DMS
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_sel  input  1  device selected (bus device code matches DEV_CODE), qualifies all strobes below
i_doa  input  1  one-cycle DOA strobe: load i_data into buffer
i_start  input  1  one-cycle Start (S) strobe
i_clear  input  1  one-cycle Clear (C) strobe
i_iorst  input  1  one-cycle bus I/O reset (not qualified by i_sel)
i_msk  input  1  interrupt disable mask bit for this device
i_data  input  8  character from CPU accumulator
o_busy  output  1  Busy flag
o_done  output  1  Done flag
o_dev_ZDQQ  output  1  interrupt request
o_dev_DMS  output  6  constant DEV_CODE
o_txd  output  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset values: o_busy=0, o_done=0, o_dev_ZDQQ=0, o_txd=1, buffer=8'h00, FSM=IDLE, counters=0.
- i_iorst acts identically to i_clear.
- Buffer register:
  - Loaded on i_sel&i_doa at any time.
  - A load during Busy does not alter the character in flight.
- Start (i_sel&i_start):
  - Accepted only when FSM=IDLE. Start while Busy is ignored; the current character continues.
  - On acceptance, at the next edge: Busy=1, Done=0, shift register = buffer, FSM=START.
  - If i_doa and i_start occur in the same cycle, the new i_data is the character transmitted (bypass).
- Clear (i_sel&i_clear, or i_iorst):
  - At the next edge: Busy=0, Done=0, FSM=IDLE, o_txd=1, counters reset.
  - Aborts a character mid-frame. The line returns high immediately, so the receiver may see a framing error; this is accepted.
  - Clear wins over a simultaneous Start or completion. DOA in the same cycle still loads the buffer.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - Bit counter 0..BAUD_DIV-1.
  - START: o_txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each; bit index 0..7.
  - STOP: o_txd=1 for STOP_BITS*BAUD_DIV cycles.
- o_txd is registered. With Start sampled at edge N, o_txd falls at edge N+1. The frame lasts exactly (9+STOP_BITS)*BAUD_DIV cycles.
- Completion: at the edge ending the last stop-bit cycle, Busy=0, Done=1, FSM=IDLE.
- A Start accepted in the cycle after completion begins a new start bit with no extra idle gap.
- Done stays set until the next accepted Start, a Clear, or reset.
- o_dev_ZDQQ = registered (Done & ~i_msk), updated every cycle. It follows a Done or mask change one cycle later.
- o_dev_DMS = DEV_CODE, constant, including during reset.
- Counter widths are sized from BAUD_DIV with $clog2. There is no wrap beyond BAUD_DIV-1.

Decomposition:
- Shared package djs130_io_pkg holds:
  - device code constants (TTI=6'o10, TTO=6'o11)
  - the FSM state enum tto_state_t {IDLE, START, DATA, STOP}
  - a bus strobe struct shared with TTI
- One sub-module: djs130_baud_tick. It is a BAUD_DIV down-counter with synchronous restart, emitting a one-cycle tick at the end of each bit period.
- All remaining logic (flags, buffer, FSM, shifter) lives in djs130_tto.

Test Plan:
- Reset then idle: deassert rst_n, run 100 cycles -> o_txd=1, o_busy=0, o_done=0, o_dev_ZDQQ=0, o_dev_DMS=6'o11.
- Basic transmit, BAUD_DIV=4: DOA 8'h41 then Start -> o_txd low 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles. o_busy=1 for 40 cycles, then o_done=1. With i_msk=0, o_dev_ZDQQ=1 one cycle after Done.
- Masked interrupt: repeat 8'h41 with i_msk=1 -> o_done=1, o_dev_ZDQQ=0. Drop i_msk to 0 -> o_dev_ZDQQ=1 next cycle.
- Start while Busy plus DOA mid-frame: Start 8'h55; at cycle 10 issue DOA 8'hAA and Start -> 8'h55 frame completes unchanged in 40 cycles. A following Start sends 8'hAA.
- Clear mid-frame: Start 8'hFF; Clear during bit 3 -> next cycle o_txd=1, o_busy=0, o_done=0, o_dev_ZDQQ=0. No further line transitions.
- Simultaneous events and async reset: same-cycle DOA 8'h5A + Start -> 8'h5A sent. Same-cycle Start + Clear -> stays IDLE. rst_n pulse mid-frame -> all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/djs130_io_pkg.sv
// Shared definitions for the DJS130 programmed-I/O devices (TTI/TTO).
// Holds the device codes, the TTO transmit state type and the decoded bus strobes.
package djs130_io_pkg;

   localparam logic [5:0] DEV_TTI = 6'o10;
   localparam logic [5:0] DEV_TTO = 6'o11;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tto_state_t;

   // Device strobes after qualification with the device select
   typedef struct packed {
      logic doa;
      logic start;
      logic clear;
   } bus_strobe_t;

endpackage

// File: rtl/djs130_baud_tick.sv
// Bit-period timer: down-counter over BAUD_DIV cycles with synchronous restart.
// Emits a one-cycle tick in the last cycle of each bit period while enabled.
module djs130_baud_tick #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_restart) begin
         cnt_d = LAST;
      end else if (i_en) begin
         cnt_d = (cnt_q == '0) ? LAST : cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = i_en & ~i_restart & (cnt_q == '0);

endmodule

// File: rtl/djs130_tto.sv
// DJS130 teletype output controller: buffers a character from DOA, sends it as
// an async frame (start, 8 data LSB first, stop) on Start, then sets Done/IRQ.
module djs130_tto
   import djs130_io_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = 434,
   parameter logic [5:0]  DEV_CODE  = DEV_TTO,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sel,
   input  logic       i_doa,
   input  logic       i_start,
   input  logic       i_clear,
   input  logic       i_iorst,
   input  logic       i_msk,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_dev_ZDQQ,
   output logic [5:0] o_dev_DMS,
   output logic       o_txd
);

   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   tto_state_t  state_q, state_d;
   logic [7:0]  buf_q, buf_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_q, stop_d;
   logic        done_q, done_d;
   logic        txd_q, txd_d;
   logic        irq_q;
   logic        restart, tick;
   bus_strobe_t strb;

   always_comb begin
      strb.doa   = i_sel & i_doa;
      strb.start = i_sel & i_start;
      strb.clear = (i_sel & i_clear) | i_iorst;
   end

   djs130_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (restart),
      .i_en      (state_q != IDLE),
      .o_tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      buf_d   = strb.doa ? i_data : buf_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      done_d  = done_q;
      txd_d   = 1'b1;
      restart = 1'b0;
      case (state_q)
         IDLE: begin
            if (strb.start) begin
               state_d = START;
               // Same-cycle DOA bypasses the buffer
               shift_d = strb.doa ? i_data : buf_q;
               bit_d   = '0;
               stop_d  = 1'b0;
               done_d  = 1'b0;
               restart = 1'b1;
            end
         end
         START: begin
            txd_d = 1'b0;
            if (tick) state_d = DATA;
         end
         DATA: begin
            txd_d = shift_q[0];
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear/IORST overrides start and completion; the line is forced idle
      if (strb.clear) begin
         state_d = IDLE;
         done_d  = 1'b0;
         bit_d   = '0;
         stop_d  = 1'b0;
         txd_d   = 1'b1;
         restart = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         buf_q   <= 8'h00;
         shift_q <= 8'h00;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
         txd_q   <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
         txd_q   <= txd_d;
         irq_q   <= done_q & ~i_msk;
      end
   end

   assign o_busy     = (state_q != IDLE);
   assign o_done     = done_q;
   assign o_dev_ZDQQ = irq_q;
   assign o_dev_DMS  = DEV_CODE;
   assign o_txd      = txd_q;

endmodule

// File: tb/tb_djs130_tto.sv
// Bench for djs130_tto: frame-position model checked every cycle, plus
// directed literal expectations for the scenarios of interest.
module tb_djs130_tto;

   localparam int unsigned BAUD      = 4;
   localparam int unsigned STOPS     = 1;
   localparam int          FRAME_LEN = (9 + STOPS) * BAUD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0, doa = 1'b0, start = 1'b0, clear = 1'b0, iorst = 1'b0, msk = 1'b0;
   logic [7:0] data = 8'h00;
   logic       busy, done, irq, txd;
   logic [5:0] dms;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   djs130_tto #(
      .BAUD_DIV  (BAUD),
      .DEV_CODE  (6'o11),
      .STOP_BITS (STOPS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sel      (sel),
      .i_doa      (doa),
      .i_start    (start),
      .i_clear    (clear),
      .i_iorst    (iorst),
      .i_msk      (msk),
      .i_data     (data),
      .o_busy     (busy),
      .o_done     (done),
      .o_dev_ZDQQ (irq),
      .o_dev_DMS  (dms),
      .o_txd      (txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line level at frame bit position idx: start=0, data LSB first, then stop bits
   function automatic logic line_bit(input logic [7:0] c, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return c[idx-1];
      return 1'b1;
   endfunction

   // Model: m_pos counts cycles since the edge that accepted Start
   logic       m_active, m_done, m_irq, m_txd;
   logic [7:0] m_char, m_buf;
   int         m_pos;
   wire        clr_now = (sel & clear) | iorst;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_pos    <= 0;
         m_char   <= 8'h00;
         m_buf    <= 8'h00;
         m_done   <= 1'b0;
         m_irq    <= 1'b0;
         m_txd    <= 1'b1;
      end else begin
         m_irq <= m_done & ~msk;
         if (sel && doa) m_buf <= data;
         m_txd <= (m_active && !clr_now) ? line_bit(m_char, m_pos / BAUD) : 1'b1;
         if (clr_now) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pos    <= 0;
         end else if (!m_active && sel && start) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_done   <= 1'b0;
            m_char   <= doa ? data : m_buf;
         end else if (m_active) begin
            if (m_pos == FRAME_LEN - 1) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("model_txd", {31'd0, txd}, {31'd0, m_txd});
         chk("model_busy", {31'd0, busy}, {31'd0, m_active});
         chk("model_done", {31'd0, done}, {31'd0, m_done});
         chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
         chk("model_dms", {26'd0, dms}, 32'o11);
      end
   end

   // One-cycle strobe; returns just after the edge that samples it
   task automatic pulse(input logic d, input logic s, input logic c, input logic [7:0] v);
      @(posedge clk);
      #1;
      sel = 1'b1; doa = d; start = s; clear = c; data = v;
      @(posedge clk);
      #1;
      sel = 1'b0; doa = 1'b0; start = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic chk_line(input string name, input int n0, input int idx, input logic exp);
      wait_cyc(n0 + 2 + BAUD * idx);
      chk(name, {31'd0, txd}, {31'd0, exp});
   endtask

   initial begin
      logic [9:0] line41;
      int n0;
      line41 = 10'b1_01000001_0;

      // Reset then idle
      #23 rst_n = 1'b1;
      cmp_en = 1'b1;
      wait_cyc(cyc + 100);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_dms", {26'd0, dms}, 32'o11);

      // Basic transmit of 'A'
      pulse(1'b1, 1'b0, 1'b0, 8'h41);
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      for (int i = 0; i < 10; i++) chk_line("a_line", n0, i, line41[i]);
      wait_cyc(n0 + 39);
      chk("a_busy_last", {31'd0, busy}, 32'd1);
      wait_cyc(n0 + 40);
      chk("a_busy_end", {31'd0, busy}, 32'd0);
      chk("a_done", {31'd0, done}, 32'd1);
      chk("a_irq_lag", {31'd0, irq}, 32'd0);
      wait_cyc(n0 + 41);
      chk("a_irq", {31'd0, irq}, 32'd1);

      // Masked interrupt
      msk = 1'b1;
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      wait_cyc(n0 + 45);
      chk("m_done", {31'd0, done}, 32'd1);
      chk("m_irq_masked", {31'd0, irq}, 32'd0);
      @(posedge clk);
      #1 msk = 1'b0;
      @(negedge clk);
      chk("m_irq_pending", {31'd0, irq}, 32'd0);
      @(negedge clk);
      chk("m_irq_unmask", {31'd0, irq}, 32'd1);

      // Start while busy, DOA mid-frame
      pulse(1'b1, 1'b0, 1'b0, 8'h55);
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      wait_cyc(n0 + 9);
      pulse(1'b1, 1'b1, 1'b0, 8'hAA);
      chk_line("b_bit3_55", n0, 4, 1'b0);
      chk_line("b_bit6_55", n0, 7, 1'b1);
      wait_cyc(n0 + 40);
      chk("b_done", {31'd0, done}, 32'd1);
      chk("b_busy", {31'd0, busy}, 32'd0);
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      chk_line("b_bit0_aa", n0, 1, 1'b0);
      chk_line("b_bit1_aa", n0, 2, 1'b1);
      wait_cyc(n0 + 41);

      // Clear mid-frame
      pulse(1'b1, 1'b0, 1'b0, 8'hFF);
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      chk_line("c_start", n0, 0, 1'b0);
      wait_cyc(n0 + 16);
      chk("c_busy_pre", {31'd0, busy}, 32'd1);
      pulse(1'b0, 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      chk("c_txd", {31'd0, txd}, 32'd1);
      chk("c_busy", {31'd0, busy}, 32'd0);
      chk("c_done", {31'd0, done}, 32'd0);
      chk("c_irq", {31'd0, irq}, 32'd0);
      wait_cyc(cyc + 40);
      chk("c_txd_idle", {31'd0, txd}, 32'd1);
      chk("c_done_idle", {31'd0, done}, 32'd0);

      // Same-cycle DOA + Start bypasses the buffer (which holds FF)
      pulse(1'b1, 1'b1, 1'b0, 8'h5A);
      n0 = cyc;
      chk_line("s_bit0_5a", n0, 1, 1'b0);
      chk_line("s_bit1_5a", n0, 2, 1'b1);
      wait_cyc(n0 + 41);
      chk("s_done", {31'd0, done}, 32'd1);

      // Start + Clear together stays idle and drops Done
      pulse(1'b0, 1'b1, 1'b1, 8'h00);
      @(negedge clk);
      chk("sc_busy", {31'd0, busy}, 32'd0);
      chk("sc_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("sc_txd", {31'd0, txd}, 32'd1);

      // IORST acts as Clear without select
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      wait_cyc(cyc + 6);
      @(posedge clk);
      #1 iorst = 1'b1;
      @(posedge clk);
      #1 iorst = 1'b0;
      @(negedge clk);
      chk("io_busy", {31'd0, busy}, 32'd0);
      chk("io_txd", {31'd0, txd}, 32'd1);

      // Asynchronous reset mid-frame
      pulse(1'b0, 1'b1, 1'b0, 8'h00);
      n0 = cyc;
      wait_cyc(n0 + 6);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2;
      chk("ar_txd", {31'd0, txd}, 32'd1);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_done", {31'd0, done}, 32'd0);
      chk("ar_irq", {31'd0, irq}, 32'd0);
      chk("ar_dms", {26'd0, dms}, 32'o11);
      @(posedge clk);
      #4 rst_n = 1'b1;
      wait_cyc(cyc + 20);
      chk("ar_idle_txd", {31'd0, txd}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
